// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver states, frame geometry and the
// baud_select code table used by both ends of the link.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;
    localparam int FRAME_BITS   = 11;
    localparam int DATA_BITS    = FRAME_BITS - 3;

    localparam logic [3:0] TICK_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_SAMPLE = 4'(SAMPLE_POINT - 1);
    localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

    function automatic int unsigned baud_rate(
        input logic [2:0] code
    );
        case (code)
            3'b000:  return 300;
            3'b001:  return 1200;
            3'b010:  return 4800;
            3'b011:  return 9600;
            3'b100:  return 19200;
            3'b101:  return 38400;
            3'b110:  return 57600;
            default: return 115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Oversampling tick generator: one sample_enable pulse every
// CLK_HZ / (16 * baud) clocks for the selected baud code.
module UARTBaudController
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);

    function automatic logic [23:0] tick_last(
        input logic [2:0] code
    );
        int unsigned div;
        div = CLK_HZ / (baud_rate(code) * OVERSAMPLE);
        if (div == 0) begin
            div = 1;
        end
        return 24'(div - 1);
    endfunction

    logic [23:0] div_count;
    logic [23:0] div_last;

    // Terminal count for the current code; >= keeps a code change safe.
    always_comb begin
        div_last      = tick_last(baud_select);
        sample_enable = (div_count >= div_last);
    end

    // Free-running divider restarting on every tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_count <= '0;
        end else if (sample_enable) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 24'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 2-FF line synchroniser, start-edge detector and
// an oversampled frame FSM (8 data bits, even parity, one stop bit).
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    logic       sample_enable;
    logic       rx_sync1;
    logic       rx_sync2;
    logic       rx_prev;
    logic       fall_edge;

    rx_state_t  state;
    rx_state_t  state_next;
    logic [3:0] tick_cnt;
    logic [3:0] tick_next;
    logic [2:0] bit_idx;
    logic [2:0] bit_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       parity_bit;
    logic       parity_next;
    logic [7:0] data_next;
    logic       valid_next;
    logic       perr_next;
    logic       ferr_next;

    UARTBaudController #(
        .CLK_HZ(CLK_HZ)
    ) baud_controller_0 (
        .clk          (clk),
        .reset        (reset),
        .baud_select  (baud_select),
        .sample_enable(sample_enable)
    );

    // Bring the asynchronous line into the clk domain; idle level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= Rx_D;
            rx_sync2 <= rx_sync1;
        end
    end

    // Previous line value; parked high while disabled so only a real
    // high->low transition after enable can start a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev <= 1'b1;
        end else if (!Rx_EN) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_sync2;
        end
    end

    assign fall_edge = rx_prev & ~rx_sync2;

    // Frame FSM: next state, counters, datapath and strobe decisions.
    always_comb begin
        state_next  = state;
        tick_next   = tick_cnt;
        bit_next    = bit_idx;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        data_next   = Rx_DATA;
        valid_next  = 1'b0;
        perr_next   = 1'b0;
        ferr_next   = 1'b0;

        if (!Rx_EN) begin
            state_next = IDLE;
            tick_next  = '0;
            bit_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_next = '0;
                    bit_next  = '0;
                    if (fall_edge) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (sample_enable) begin
                        tick_next = tick_cnt + 4'd1;
                        if (tick_cnt == TICK_SAMPLE) begin
                            tick_next  = '0;
                            bit_next   = '0;
                            state_next = rx_sync2 ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample_enable) begin
                        tick_next = tick_cnt + 4'd1;
                        if (tick_cnt == TICK_LAST) begin
                            shift_next = {rx_sync2, shift_reg[7:1]};
                            bit_next   = bit_idx + 3'd1;
                            if (bit_idx == BIT_LAST) begin
                                state_next = PARITY;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (sample_enable) begin
                        tick_next = tick_cnt + 4'd1;
                        if (tick_cnt == TICK_LAST) begin
                            parity_next = rx_sync2;
                            state_next  = STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample_enable) begin
                        tick_next = tick_cnt + 4'd1;
                        if (tick_cnt == TICK_LAST) begin
                            state_next = IDLE;
                            perr_next  = parity_bit != ^shift_reg;
                            ferr_next  = ~rx_sync2;
                            if (rx_sync2 && !perr_next) begin
                                valid_next = 1'b1;
                                data_next  = shift_reg;
                            end
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM, datapath and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            Rx_DATA    <= 8'h00;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            bit_idx    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            Rx_DATA    <= data_next;
            Rx_VALID   <= valid_next;
            Rx_PERROR  <= perr_next;
            Rx_FERROR  <= ferr_next;
        end
    end

endmodule
